// File: rtl/piton_pkg.sv
// Shared piton NoC channel definitions and defaults used by endpoints and routers.
package piton_pkg;

    localparam int unsigned NOC_DATA_WIDTH        = 64;
    localparam int unsigned PITON_DEFAULT_CREDITS = 4;

    typedef struct packed {
        logic [NOC_DATA_WIDTH-1:0] data;
        logic                      valid;
        logic                      yummy;
    } piton_chan_t;

    // Pointer width that stays at least one bit for tiny depths.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/piton_credit_fifo.sv
// Synchronous FIFO with first-word fall-through head, occupancy count and full/empty flags.
module piton_credit_fifo
    import piton_pkg::*;
#(
    parameter int unsigned DW    = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [DW-1:0]                push_data,
    input  logic                         pop,
    output logic [DW-1:0]                head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned AW = ptr_width(DEPTH);
    localparam int unsigned PW = $clog2(DEPTH + 1);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          wr_en;
    logic          rd_en;

    // Wrap at DEPTH explicitly so non-power-of-two depths work.
    function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign full  = (count == PW'(DEPTH));
    assign empty = (count == '0);
    assign wr_en = push & (~full | pop);
    assign rd_en = pop & ~empty;
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= bump(wr_ptr);
            if (rd_en) rd_ptr <= bump(rd_ptr);
            unique case ({wr_en, rd_en})
                2'b10:   count <= count + PW'(1);
                2'b01:   count <= count - PW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; the pointers define validity.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/piton_credit_endp.sv
// Endpoint peer of a piton valid/yummy router port: credit-tracked TX injection and
// buffered RX ejection that returns one yummy per consumed flit.
module piton_credit_endp
    import piton_pkg::*;
#(
    parameter int unsigned CREDITS  = PITON_DEFAULT_CREDITS,
    parameter int unsigned RX_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  piton_chan_t                       chan_in,
    output piton_chan_t                       chan_out,
    input  logic [NOC_DATA_WIDTH-1:0]         tx_data,
    input  logic                              tx_valid,
    output logic                              tx_ready,
    output logic [NOC_DATA_WIDTH-1:0]         rx_data,
    output logic                              rx_valid,
    input  logic                              rx_ready,
    output logic [$clog2(CREDITS+1)-1:0]      tx_credits,
    output logic [$clog2(RX_DEPTH+1)-1:0]     rx_count,
    output logic                              err_credit_ovf,
    output logic                              err_rx_ovf
);

    localparam int unsigned CW = $clog2(CREDITS + 1);

    logic          send;
    logic          pop;
    logic          rx_full;
    logic          rx_empty;
    logic [CW-1:0] credits_next;
    logic          credit_ovf_next;

    assign tx_ready = (tx_credits != '0);
    assign send     = tx_valid & tx_ready;
    assign rx_valid = ~rx_empty;
    assign pop      = rx_valid & rx_ready;

    // Send and yummy in the same cycle cancel; a surplus yummy saturates and flags.
    always_comb begin
        credits_next    = tx_credits;
        credit_ovf_next = err_credit_ovf;
        unique case ({send, chan_in.yummy})
            2'b10: credits_next = tx_credits - CW'(1);
            2'b01: begin
                if (tx_credits == CW'(CREDITS)) credit_ovf_next = 1'b1;
                else                            credits_next    = tx_credits + CW'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_credits     <= CW'(CREDITS);
            err_credit_ovf <= 1'b0;
            err_rx_ovf     <= 1'b0;
            chan_out       <= '0;
        end else begin
            tx_credits     <= credits_next;
            err_credit_ovf <= credit_ovf_next;
            err_rx_ovf     <= err_rx_ovf | (chan_in.valid & rx_full & ~pop);
            chan_out.valid <= send;
            chan_out.yummy <= pop;
            if (send) chan_out.data <= tx_data;
        end
    end

    piton_credit_fifo #(
        .DW    (NOC_DATA_WIDTH),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (chan_in.valid),
        .push_data (chan_in.data),
        .pop       (pop),
        .head      (rx_data),
        .count     (rx_count),
        .full      (rx_full),
        .empty     (rx_empty)
    );

endmodule
